glitch_sweep: RTL and testbench

- Campaign sequencer that drives the cmd-side glitch controls: glitch_en, delay_out and width_out.
- Feeds the existing resetter, delay and pulse chain in place of single manual shots.
- Sweeps a delay × width grid and repeats each point. After each shot it watches a success indication (hit_in) during a settle window.
- Reports the first hit, or reports completion of the grid.

---
 rtl/glitch_pkg.sv | 22 ++
 rtl/glitch_sweep_axis.sv | 58 +++++
 rtl/glitch_sweep.sv | 218 +++++++++++++++++++++
 tb/tb_glitch_sweep.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_pkg.sv
// glitch_pkg
//   Shared definitions for the glitch campaign sequencer:
//   - default widths for the delay / pulse-width datapaths
//   - default settle window (target reboot time, in clock cycles)
//   - campaign FSM state encoding
package glitch_pkg;

    localparam int DELAY_W_DEF       = 16;
    localparam int WIDTH_W_DEF       = 8;
    localparam int SETTLE_CYCLES_DEF = 1200000;
    localparam int REP_W_DEF         = 4;
    localparam int CNT_W_DEF         = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_WAIT = 3'd2,
        ST_NEXT = 3'd3,
        ST_FIN  = 3'd4
    } glitch_state_e;

endpackage

// File: rtl/glitch_sweep_axis.sv
// sweep_axis
//   One axis of the sweep grid: a start/end/step stepper.
//   On load it captures start/end/step (step 0 becomes 1) and presents
//   start on value. On advance it either steps forward or, when the next
//   step would leave the range, returns to start. wrap tells the parent
//   ahead of time which of the two an advance would do, so the parent can
//   decide whether to carry into the next axis.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   load                capture cfg_* and set value = cfg_start
//   advance             step (or return to start when wrap is high)
//   cfg_start/end/step  range definition, sampled on load only
//   value               current axis value
//   wrap                next step overflows W bits or passes the end value
module sweep_axis
    import glitch_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         advance,
    input  logic [W-1:0] cfg_start,
    input  logic [W-1:0] cfg_end,
    input  logic [W-1:0] cfg_step,
    output logic [W-1:0] value,
    output logic         wrap
);

    logic [W-1:0] start_q;
    logic [W-1:0] end_q;
    logic [W-1:0] step_q;
    logic [W:0]   sum;

    // One extra bit so a carry out of W bits counts as "past the end"
    // instead of wrapping to a small value.
    assign sum  = {1'b0, value} + {1'b0, step_q};
    assign wrap = (sum > {1'b0, end_q});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value   <= '0;
            start_q <= '0;
            end_q   <= '0;
            step_q  <= '0;
        end else if (load) begin
            value   <= cfg_start;
            start_q <= cfg_start;
            end_q   <= cfg_end;
            step_q  <= (cfg_step == '0) ? W'(1) : cfg_step;
        end else if (advance) begin
            value <= wrap ? start_q : sum[W-1:0];
        end
    end

endmodule

// File: rtl/glitch_sweep.sv
// glitch_sweep
//   Campaign sequencer for the glitch chain. Walks a delay x width grid
//   (delay is the inner loop), fires cfg_repeat shots per grid point and,
//   after each shot, watches hit_in for SETTLE_CYCLES cycles. Records the
//   first hit and optionally ends the campaign on it.
//
//   Shot timing: ARM (1 cycle, glitch_en) -> WAIT (SETTLE_CYCLES cycles)
//   -> NEXT (1 cycle) -> ARM ..., so shots are SETTLE_CYCLES + 2 apart.
//
//   start/abort are single-cycle requests sampled on the rising edge; there
//   is no backpressure. start is honoured only in IDLE, abort only in
//   ARM/WAIT/NEXT; a request arriving in any other state is dropped.
//
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   start, abort                 campaign control requests
//   cfg_delay_start/end/step     delay axis range (latched on start)
//   cfg_width_start/end/step     width axis range (latched on start)
//   cfg_repeat                   shots per grid point (0 acts as 1)
//   cfg_stop_on_hit              end campaign on first hit
//   hit_in                       success indication, sampled in WAIT only
//   glitch_en                    one-cycle shot trigger
//   delay_out, width_out         current grid point
//   busy, done                   not-idle level / end-of-campaign pulse
//   hit_valid, hit_delay/width   first-hit record (sticky until next start)
//   attempt_cnt                  saturating shot counter
//   fsm_state                    debug view of the campaign FSM state
module glitch_sweep
    import glitch_pkg::*;
#(
    parameter int DELAY_W       = DELAY_W_DEF,
    parameter int WIDTH_W       = WIDTH_W_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int REP_W         = REP_W_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [DELAY_W-1:0] cfg_delay_start,
    input  logic [DELAY_W-1:0] cfg_delay_end,
    input  logic [DELAY_W-1:0] cfg_delay_step,
    input  logic [WIDTH_W-1:0] cfg_width_start,
    input  logic [WIDTH_W-1:0] cfg_width_end,
    input  logic [WIDTH_W-1:0] cfg_width_step,
    input  logic [REP_W-1:0]   cfg_repeat,
    input  logic               cfg_stop_on_hit,
    input  logic               hit_in,
    output logic               glitch_en,
    output logic [DELAY_W-1:0] delay_out,
    output logic [WIDTH_W-1:0] width_out,
    output logic               busy,
    output logic               done,
    output logic               hit_valid,
    output logic [DELAY_W-1:0] hit_delay,
    output logic [WIDTH_W-1:0] hit_width,
    output logic [CNT_W-1:0]   attempt_cnt,
    output glitch_state_e      fsm_state
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

    glitch_state_e state;
    glitch_state_e state_next;

    logic [SET_W-1:0] settle_cnt;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_q;
    logic             stop_q;
    logic [REP_W:0]   rep_inc;

    logic start_ok;
    logic point_done;
    logic sweep_end;
    logic step_ok;
    logic d_adv;
    logic w_adv;
    logic d_wrap;
    logic w_wrap;

    assign start_ok = (state == ST_IDLE) && start;
    assign step_ok  = (state == ST_NEXT) && !abort;

    // rep_cnt holds shots already completed at this point, so rep_inc is
    // the count including the shot that just finished.
    assign rep_inc    = {1'b0, rep_cnt} + (REP_W + 1)'(1);
    assign point_done = (rep_inc >= {1'b0, rep_q});

    // Both axes wrapping means the grid is exhausted; neither axis moves
    // so the last point stays visible on delay_out/width_out.
    assign sweep_end = point_done && d_wrap && w_wrap;
    assign d_adv     = step_ok && point_done && !sweep_end;
    assign w_adv     = step_ok && point_done && d_wrap && !w_wrap;

    sweep_axis #(.W(DELAY_W)) u_delay_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (start_ok),
        .advance   (d_adv),
        .cfg_start (cfg_delay_start),
        .cfg_end   (cfg_delay_end),
        .cfg_step  (cfg_delay_step),
        .value     (delay_out),
        .wrap      (d_wrap)
    );

    sweep_axis #(.W(WIDTH_W)) u_width_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (start_ok),
        .advance   (w_adv),
        .cfg_start (cfg_width_start),
        .cfg_end   (cfg_width_end),
        .cfg_step  (cfg_width_step),
        .value     (width_out),
        .wrap      (w_wrap)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_ARM;
            end
            ST_ARM: begin
                state_next = abort ? ST_FIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (abort || (hit_in && stop_q)) begin
                    state_next = ST_FIN;
                end else if (settle_cnt == SET_LAST) begin
                    state_next = ST_NEXT;
                end
            end
            ST_NEXT: begin
                state_next = (abort || sweep_end) ? ST_FIN : ST_ARM;
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        glitch_en = (state == ST_ARM);
        busy      = (state != ST_IDLE);
        done      = (state == ST_FIN);
    end

    assign fsm_state = state;

    // Campaign datapath: shadow config, settle/repeat counters, hit record
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_cnt  <= '0;
            rep_cnt     <= '0;
            rep_q       <= '0;
            stop_q      <= 1'b0;
            hit_valid   <= 1'b0;
            hit_delay   <= '0;
            hit_width   <= '0;
            attempt_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rep_q       <= (cfg_repeat == '0) ? REP_W'(1) : cfg_repeat;
                        stop_q      <= cfg_stop_on_hit;
                        rep_cnt     <= '0;
                        hit_valid   <= 1'b0;
                        hit_delay   <= '0;
                        hit_width   <= '0;
                        attempt_cnt <= '0;
                    end
                end
                ST_ARM: begin
                    settle_cnt <= '0;
                    if (attempt_cnt != '1) begin
                        attempt_cnt <= attempt_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    settle_cnt <= settle_cnt + SET_W'(1);
                    // Captured even when abort arrives in the same cycle.
                    if (hit_in && !hit_valid) begin
                        hit_valid <= 1'b1;
                        hit_delay <= delay_out;
                        hit_width <= width_out;
                    end
                end
                ST_NEXT: begin
                    if (!abort) begin
                        rep_cnt <= point_done ? '0 : rep_inc[REP_W-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glitch_sweep.sv
module tb_glitch_sweep;
    import glitch_pkg::*;

    localparam int DW = 16;
    localparam int WW = 8;
    localparam int SC = 4;
    localparam int SPACING = SC + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic          start, abort, hit_in, stop_on_hit;
    logic [DW-1:0] d_start, d_end, d_step;
    logic [WW-1:0] w_start, w_end, w_step;
    logic [3:0]    rep;
    logic          glitch_en, busy, done, hit_valid;
    logic [DW-1:0] delay_out, hit_delay;
    logic [WW-1:0] width_out, hit_width;
    logic [31:0]   attempt_cnt;
    glitch_state_e dut_state;

    glitch_sweep #(
        .DELAY_W(DW), .WIDTH_W(WW), .SETTLE_CYCLES(SC), .REP_W(4), .CNT_W(32)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .cfg_delay_start (d_start),
        .cfg_delay_end   (d_end),
        .cfg_delay_step  (d_step),
        .cfg_width_start (w_start),
        .cfg_width_end   (w_end),
        .cfg_width_step  (w_step),
        .cfg_repeat      (rep),
        .cfg_stop_on_hit (stop_on_hit),
        .hit_in          (hit_in),
        .glitch_en       (glitch_en),
        .delay_out       (delay_out),
        .width_out       (width_out),
        .busy            (busy),
        .done            (done),
        .hit_valid       (hit_valid),
        .hit_delay       (hit_delay),
        .hit_width       (hit_width),
        .attempt_cnt     (attempt_cnt),
        .fsm_state       (dut_state)
    );

    // ---------------- scoreboard ----------------
    logic [DW+WW-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int start_cyc = 0;
    int camp_shots = 0;
    int last_shot = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Every shot must match the head of the expected queue and keep the
    // fixed spacing; a shot with nothing queued is an extra shot.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && glitch_en === 1'b1) begin
            check("shot_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                check("shot_point", 64'({delay_out, width_out}), 64'(exp_q.pop_front()));
            end
            if (camp_shots == 0) check("first_shot_cyc", 64'(cyc), 64'(start_cyc + 1));
            else                 check("shot_spacing", 64'(cyc - last_shot), 64'(SPACING));
            camp_shots++;
            last_shot = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_cfg(input logic [DW-1:0] ds, de, dst,
                           input logic [WW-1:0] ws, we, wst,
                           input logic [3:0] r, input logic soh);
        d_start = ds; d_end = de; d_step = dst;
        w_start = ws; w_end = we; w_step = wst;
        rep = r; stop_on_hit = soh;
    endtask

    task automatic push_pt(input logic [DW-1:0] d, input logic [WW-1:0] w);
        exp_q.push_back({d, w});
    endtask

    // Called at a negedge; returns at the negedge of the ARM cycle.
    task automatic do_start();
        start = 1'b1;
        start_cyc = cyc;
        camp_shots = 0;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int max_cyc, input int exp_cyc);
        int dc;
        dc = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dc = cyc;
                break;
            end
        end
        check(tag, 64'(dc), 64'(exp_cyc));
    endtask

    task automatic basic_grid(input logic soh);
        set_cfg(16'd10, 16'd14, 16'd2, 8'd1, 8'd2, 8'd1, 4'd1, soh);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; hit_in = 1'b0;
        set_cfg('0, '0, '0, '0, '0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        check("reset_state", 64'(dut_state), 64'(ST_IDLE));
        check("reset_outputs", 64'({glitch_en, busy, done, hit_valid, delay_out, width_out}), 64'd0);
        check("reset_attempt", 64'(attempt_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic grid; hits outside WAIT (ARM, NEXT) must be ignored.
        basic_grid(1'b0);
        push_pt(16'd10, 8'd1); push_pt(16'd12, 8'd1); push_pt(16'd14, 8'd1);
        push_pt(16'd10, 8'd2); push_pt(16'd12, 8'd2); push_pt(16'd14, 8'd2);
        do_start();
        check("basic_busy", 64'(busy), 64'd1);
        hit_in = 1'b1;
        @(negedge clk);
        hit_in = 1'b0;
        wait_cyc(start_cyc + 6);
        hit_in = 1'b1;
        @(negedge clk);
        hit_in = 1'b0;
        wait_done("basic_done_cyc", 60, start_cyc + 37);
        check("basic_attempts", 64'(attempt_cnt), 64'd6);
        check("basic_no_hit", 64'(hit_valid), 64'd0);
        check("basic_hold_point", 64'({delay_out, width_out}), 64'({16'd14, 8'd2}));
        check("basic_all_shots", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check("basic_busy_fall", 64'(busy), 64'd0);

        // Repeat 3 with zero steps; abort alongside start must not block it.
        set_cfg(16'd5, 16'd5, 16'd0, 8'd3, 8'd3, 8'd0, 4'd3, 1'b0);
        repeat (3) push_pt(16'd5, 8'd3);
        abort = 1'b1;
        do_start();
        wait_done("rep_done_cyc", 40, start_cyc + 19);
        check("rep_attempts", 64'(attempt_cnt), 64'd3);
        check("rep_all_shots", 64'(exp_q.size()), 64'd0);
        @(negedge clk);

        // Stop on hit in the second window.
        basic_grid(1'b1);
        push_pt(16'd10, 8'd1); push_pt(16'd12, 8'd1);
        do_start();
        wait_cyc(start_cyc + 9);
        hit_in = 1'b1;
        wait_done("soh_done_cyc", 20, start_cyc + 10);
        hit_in = 1'b0;
        check("soh_hit_valid", 64'(hit_valid), 64'd1);
        check("soh_hit_delay", 64'(hit_delay), 64'd12);
        check("soh_hit_width", 64'(hit_width), 64'd1);
        check("soh_attempts", 64'(attempt_cnt), 64'd2);
        repeat (20) @(negedge clk);
        check("soh_no_third_shot", 64'(camp_shots), 64'd2);

        // Delay overflow: FFFE + 3 carries out, so width advances instead.
        set_cfg(16'hFFFE, 16'hFFFF, 16'd3, 8'd1, 8'd2, 8'd1, 4'd1, 1'b0);
        push_pt(16'hFFFE, 8'd1); push_pt(16'hFFFE, 8'd2);
        do_start();
        check("ovf_hit_cleared", 64'(hit_valid), 64'd0);
        wait_done("ovf_done_cyc", 40, start_cyc + 13);
        check("ovf_attempts", 64'(attempt_cnt), 64'd2);
        check("ovf_hold_point", 64'({delay_out, width_out}), 64'({16'hFFFE, 8'd2}));
        @(negedge clk);

        // Start while busy (with changed cfg) ignored; abort in WAIT of shot 2.
        basic_grid(1'b0);
        push_pt(16'd10, 8'd1); push_pt(16'd12, 8'd1);
        do_start();
        wait_cyc(start_cyc + 3);
        start = 1'b1; d_start = 16'd100;
        @(negedge clk);
        start = 1'b0; d_start = 16'd10;
        check("busy_start_attempts", 64'(attempt_cnt), 64'd1);
        wait_cyc(start_cyc + 9);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_done", 64'(done), 64'd1);
        @(negedge clk);
        check("abort_busy_fall", 64'(busy), 64'd0);
        repeat (20) @(negedge clk);
        check("abort_attempts", 64'(attempt_cnt), 64'd2);
        check("abort_shots", 64'(camp_shots), 64'd2);
        check("abort_hold_delay", 64'(delay_out), 64'd12);

        // Reset mid-campaign after a hit has been recorded.
        basic_grid(1'b0);
        push_pt(16'd10, 8'd1); push_pt(16'd12, 8'd1);
        do_start();
        wait_cyc(start_cyc + 3);
        hit_in = 1'b1;
        @(negedge clk);
        hit_in = 1'b0;
        wait_cyc(start_cyc + 9);
        check("pre_rst_hit_delay", 64'({hit_valid, hit_delay}), 64'({1'b1, 16'd10}));
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_state", 64'(dut_state), 64'(ST_IDLE));
        check("rst_outputs", 64'({glitch_en, busy, done, hit_valid, delay_out, width_out}), 64'd0);
        check("rst_hit_regs", 64'({hit_delay, hit_width}), 64'd0);
        check("rst_attempt", 64'(attempt_cnt), 64'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_no_more_shots", 64'(camp_shots), 64'd2);

        // Hit in the final WAIT cycle, sweep continues, later hit ignored.
        basic_grid(1'b0);
        push_pt(16'd10, 8'd1); push_pt(16'd12, 8'd1); push_pt(16'd14, 8'd1);
        push_pt(16'd10, 8'd2); push_pt(16'd12, 8'd2); push_pt(16'd14, 8'd2);
        do_start();
        wait_cyc(start_cyc + 5);
        hit_in = 1'b1;
        @(negedge clk);
        hit_in = 1'b0;
        check("last_wait_hit", 64'({hit_valid, hit_delay, hit_width}), 64'({1'b1, 16'd10, 8'd1}));
        wait_cyc(start_cyc + 14);
        hit_in = 1'b1;
        @(negedge clk);
        hit_in = 1'b0;
        wait_done("late_done_cyc", 60, start_cyc + 37);
        check("late_hit_kept", 64'({hit_delay, hit_width}), 64'({16'd10, 8'd1}));
        check("late_attempts", 64'(attempt_cnt), 64'd6);
        check("late_all_shots", 64'(exp_q.size()), 64'd0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
